// File: rtl/regfile_sb_bypass.sv
// Multi-read-port register file with same-cycle write bypass, optional hardwired-zero R0,
// and a per-register busy scoreboard that decode reserves at issue and writeback clears.
module regfile_sb_bypass #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_gnt,
    input  logic                     flush,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(NUM_REGS));
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Read ports: register lookup, then bypass override, then the R0 override wins.
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              rbsy;

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        rdat    = '0;
        rbsy    = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra   = rd_addr[i*ADDR_W +: ADDR_W];
            rdat = '0;
            rbsy = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (ra == ADDR_W'(r)) begin
                    rdat = regs[r];
                    rbsy = busy[r];
                end
            end
            if (BYPASS && wr_en && (wr_addr == ra) && in_range(ra)) begin
                rdat = wr_data;
                rbsy = 1'b0;
            end
            if (is_zero(ra)) begin
                rdat = '0;
                rbsy = 1'b0;
            end
            rd_data[i*DATA_W +: DATA_W] = rdat;
            rd_busy[i]                  = rbsy;
        end
    end

    // A WAW reservation is refused while the register is pending, unless its
    // producer retires in this same cycle.
    logic rsv_busy;
    logic wr_hit_rsv;

    always_comb begin
        rsv_busy = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rsv_addr == ADDR_W'(r))
                rsv_busy = busy[r];
        end
        wr_hit_rsv = wr_en && (wr_addr == rsv_addr);
        rsv_gnt    = rsv_en && !flush && in_range(rsv_addr) && (!rsv_busy || wr_hit_rsv);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
            busy <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr_en && (wr_addr == ADDR_W'(r)) && !(ZERO_REG && (r == 0)))
                    regs[r] <= wr_data;
            end
            if (flush) begin
                busy <= '0;
            end else begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (rsv_gnt && (rsv_addr == ADDR_W'(r)) && !(ZERO_REG && (r == 0)))
                        busy[r] <= 1'b1;
                    else if (wr_en && (wr_addr == ADDR_W'(r)))
                        busy[r] <= 1'b0;
                end
            end
        end
    end

    assign busy_vec = busy;

endmodule
